seg_scan_capture: RTL and testbench

SEG_SCAN_CAPTURE -- requirements
Module: seg_scan_capture

---
 rtl/seg_scan_capture.sv | 143 ++++++++++++++
 tb/tb_seg_scan_capture.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_capture.sv
// seg_scan_capture: captures a multiplexed 7-segment display bus into decoded digit frames.
// Each digit is accepted only after STABLE_CYC identical registered samples.
module seg_scan_capture #(
    parameter int NUM_DIG    = 4,
    parameter int STABLE_CYC = 4
) (
    input  logic                   clk_in,
    input  logic                   rst_n_in,
    input  logic [7:0]             seg_data_in,
    input  logic [NUM_DIG-1:0]     sel_in,
    input  logic                   frame_ready_in,
    output logic [4*NUM_DIG-1:0]   digits_out,
    output logic [NUM_DIG-1:0]     dp_out,
    output logic                   frame_valid_out,
    output logic                   err_out,
    output logic                   overrun_out
);
    localparam int CW = $clog2(STABLE_CYC + 1);
    typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

    state_t               state_q, state_d;
    logic [NUM_DIG-1:0]   sel_q, ref_sel_q, ref_sel_d, seen_q, seen_d;
    logic [NUM_DIG-1:0]   wdp_q, wdp_d, dp_q, dp_d;
    logic [7:0]           seg_q, ref_seg_q, ref_seg_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [4*NUM_DIG-1:0] wcode_q, wcode_d, digits_q, digits_d;
    logic                 valid_q, valid_d, err_q, err_d, ovr_q, ovr_d;
    logic                 onehot, same, cap, complete;
    logic [4:0]           dec;

    // {unrecognised, code}
    function automatic logic [4:0] decode(input logic [6:0] p);
        case (p)
            7'h3F:   decode = 5'h00;
            7'h06:   decode = 5'h01;
            7'h5B:   decode = 5'h02;
            7'h4F:   decode = 5'h03;
            7'h66:   decode = 5'h04;
            7'h6D:   decode = 5'h05;
            7'h7D:   decode = 5'h06;
            7'h07:   decode = 5'h07;
            7'h7F:   decode = 5'h08;
            7'h6F:   decode = 5'h09;
            7'h40:   decode = 5'h0A;
            7'h00:   decode = 5'h0B;
            default: decode = 5'h1E;
        endcase
    endfunction

    always_comb begin
        onehot    = (sel_q != '0) && ((sel_q & (sel_q - NUM_DIG'(1))) == '0);
        same      = {sel_q, seg_q} == {ref_sel_q, ref_seg_q};
        state_d   = state_q;
        cnt_d     = cnt_q;
        ref_sel_d = ref_sel_q;
        ref_seg_d = ref_seg_q;
        cap       = 1'b0;
        if (state_q == SETTLE && same) begin
            cnt_d   = (cnt_q == CW'(STABLE_CYC)) ? cnt_q : cnt_q + 1'b1;
            cap     = cnt_d == CW'(STABLE_CYC);
            state_d = cap ? HOLD : SETTLE;
        end else if (state_q == HOLD && same) begin
            state_d = HOLD;
        end else begin
            // IDLE, a changed sample in SETTLE and any change in HOLD all restart here
            state_d = onehot ? SETTLE : IDLE;
            if (onehot) begin
                cnt_d     = CW'(1);
                ref_sel_d = sel_q;
                ref_seg_d = seg_q;
            end
        end
    end

    always_comb begin
        dec      = decode(ref_seg_q[6:0]);
        complete = &seen_q;
        seen_d   = complete ? '0 : seen_q;
        wcode_d  = wcode_q;
        wdp_d    = wdp_q;
        for (int i = 0; i < NUM_DIG; i++) begin
            if (cap && ref_sel_q[i]) begin
                wcode_d[4*i +: 4] = dec[3:0];
                wdp_d[i]          = ref_seg_q[7];
                seen_d[i]         = 1'b1;
            end
        end
        err_d    = err_q | (cap & dec[4]);
        digits_d = digits_q;
        dp_d     = dp_q;
        valid_d  = valid_q;
        ovr_d    = ovr_q;
        if (complete && (!valid_q || frame_ready_in)) begin
            digits_d = wcode_q;
            dp_d     = wdp_q;
            valid_d  = 1'b1;
        end else if (complete) begin
            ovr_d = 1'b1;
        end else if (frame_ready_in) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            sel_q     <= '0;
            seg_q     <= '0;
            state_q   <= IDLE;
            cnt_q     <= '0;
            ref_sel_q <= '0;
            ref_seg_q <= '0;
            seen_q    <= '0;
            wcode_q   <= '0;
            wdp_q     <= '0;
            digits_q  <= {NUM_DIG{4'hB}};
            dp_q      <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            sel_q     <= sel_in;
            seg_q     <= seg_data_in;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ref_sel_q <= ref_sel_d;
            ref_seg_q <= ref_seg_d;
            seen_q    <= seen_d;
            wcode_q   <= wcode_d;
            wdp_q     <= wdp_d;
            digits_q  <= digits_d;
            dp_q      <= dp_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            ovr_q     <= ovr_d;
        end
    end

    assign digits_out      = digits_q;
    assign dp_out          = dp_q;
    assign frame_valid_out = valid_q;
    assign err_out         = err_q;
    assign overrun_out     = ovr_q;
endmodule

// File: tb/tb_seg_scan_capture.sv
// tb_seg_scan_capture: directed scenarios plus random scans checked by a run-length reference model.
module tb_seg_scan_capture;
    localparam int N = 4;
    localparam int S = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic [7:0]   seg;
    logic [N-1:0] sel;
    logic         ready;
    logic [4*N-1:0] digits_out;
    logic [N-1:0] dp_out;
    logic         frame_valid_out, err_out, overrun_out;

    seg_scan_capture #(.NUM_DIG(N), .STABLE_CYC(S)) dut (
        .clk_in(clk), .rst_n_in(rst_n), .seg_data_in(seg), .sel_in(sel),
        .frame_ready_in(ready), .digits_out(digits_out), .dp_out(dp_out),
        .frame_valid_out(frame_valid_out), .err_out(err_out), .overrun_out(overrun_out)
    );

    int checks = 0, passes = 0, presented = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Index in this table is the decoded code (0-9, A=sign, B=blank)
    logic [6:0] pat [12] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D,
                             7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h40, 7'h00};

    function automatic logic [4:0] mdecode(input logic [6:0] p);
        for (int i = 0; i < 12; i++) if (pat[i] == p) return {1'b0, 4'(i)};
        return 5'h1E;
    endfunction

    typedef struct { int due; logic [4*N-1:0] d; logic [N-1:0] p; } frame_t;
    frame_t pend[$];
    frame_t expq[$];

    int           cyc, run;
    logic [N-1:0] prev_sel, mseen;
    logic [7:0]   prev_seg;
    logic [3:0]   mcode [N];
    logic         mdp [N];
    logic         mvalid, merr, movr;

    task automatic model_reset();
        cyc = 0; run = 0; prev_sel = '0; prev_seg = '0; mseen = '0;
        mvalid = 1'b0; merr = 1'b0; movr = 1'b0;
        for (int i = 0; i < N; i++) begin mcode[i] = 4'h0; mdp[i] = 1'b0; end
        pend.delete(); expq.delete();
    endtask

    // A digit is captured when a one-hot sample has repeated exactly S times in a row;
    // the frame completed by it is offered two edges after the input edge that finished the run.
    task automatic model_step();
        frame_t f;
        logic [4:0] dc;
        cyc++;
        if (pend.size() != 0 && pend[0].due == cyc) begin
            f = pend.pop_front();
            if (!mvalid || ready) begin mvalid = 1'b1; expq.push_back(f); end
            else movr = 1'b1;
        end else if (ready) mvalid = 1'b0;
        if ($onehot(sel) && sel == prev_sel && seg == prev_seg) run++;
        else run = $onehot(sel) ? 1 : 0;
        prev_sel = sel;
        prev_seg = seg;
        if (run == S) begin
            dc = mdecode(seg[6:0]);
            merr |= dc[4];
            for (int i = 0; i < N; i++) if (sel[i]) begin
                mcode[i] = dc[3:0]; mdp[i] = seg[7]; mseen[i] = 1'b1;
            end
            if (&mseen) begin
                f.due = cyc + 2;
                for (int i = 0; i < N; i++) begin f.d[4*i +: 4] = mcode[i]; f.p[i] = mdp[i]; end
                pend.push_back(f);
                mseen = '0;
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    bit pv = 0, pr = 0;
    logic [4*N-1:0] last_d = '0;
    logic [N-1:0]   last_p = '0;
    initial forever begin
        frame_t e;
        @(negedge clk);
        if (!rst_n) begin
            pv = 0; pr = 0;
        end else begin
            check("valid", frame_valid_out, mvalid);
            check("overrun", overrun_out, movr);
            if (frame_valid_out && (!pv || pr)) begin
                presented++;
                if (expq.size() == 0) begin
                    checks++;
                    $display("FAIL frame_unexpected: got digits 0x%0h, expected no frame", digits_out);
                end else begin
                    e = expq.pop_front();
                    check("frame_digits", digits_out, e.d);
                    check("frame_dp", dp_out, e.p);
                end
                last_d = digits_out;
                last_p = dp_out;
            end else if (frame_valid_out) begin
                check("stable_digits", digits_out, last_d);
                check("stable_dp", dp_out, last_p);
            end
            pv = frame_valid_out;
            pr = ready;
        end
    end

    task automatic drive(input logic [N-1:0] s, input logic [7:0] g, input int n);
        sel = s;
        seg = g;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic scan(input logic [31:0] g, input int h);
        for (int i = 0; i < N; i++) drive(N'(1) << i, g[8*i +: 8], h);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sel = '0;
        seg = '0;
        repeat (2) begin @(posedge clk); #1; end
        check("rst_digits", digits_out, 16'hBBBB);
        check("rst_dp", dp_out, 0);
        check("rst_valid", frame_valid_out, 0);
        check("rst_err", err_out, 0);
        check("rst_overrun", overrun_out, 0);
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int p0, lat;
        rst_n = 1'b0; sel = '0; seg = '0; ready = 1'b1;
        #1;
        do_reset();

        // 3,1,4,1 with latency of the last digit
        p0 = presented;
        for (int i = 0; i < 3; i++) drive(N'(1) << i, (i == 1) ? 8'h06 : (i == 0 ? 8'h4F : 8'h66), 6);
        sel = 4'b1000; seg = 8'h06; lat = 0;
        do begin @(negedge clk); lat++; end while (!frame_valid_out && lat < 30);
        check("latency", lat - 2, S + 1);
        @(posedge clk); #1;
        drive('0, 8'h00, 8);
        check("s1_frames", presented - p0, 1);
        check("s1_digits", digits_out, 16'h1413);
        check("s1_dp", dp_out, 0);
        check("s1_err", err_out, 0);
        check("s1_overrun", overrun_out, 0);

        // unstable digit 0 and non-one-hot selects must not capture
        p0 = presented;
        for (int i = 0; i < 8; i++) drive(4'b0001, i[0] ? 8'h06 : 8'h3F, 3);
        drive(4'b0011, 8'h5B, 8);
        drive(4'b0000, 8'h5B, 8);
        for (int i = 1; i < N; i++) drive(N'(1) << i, (i == 1) ? 8'h7D : (i == 2 ? 8'h07 : 8'h7F), 6);
        drive('0, 8'h00, 8);
        check("s2_no_frame", presented - p0, 0);
        drive(4'b0001, 8'h6D, 6);
        drive('0, 8'h00, 8);
        check("s2_frames", presented - p0, 1);
        check("s2_digits", digits_out, 16'h8765);

        // unrecognised pattern with dp on digit 2
        scan(32'h7F_C9_40_00, 6);
        drive('0, 8'h00, 8);
        check("s3_digits", digits_out, 16'h8EAB);
        check("s3_dp", dp_out, 4'b0100);
        check("s3_err", err_out, 1);

        // consumer stalled across two scans
        ready = 1'b0;
        p0 = presented;
        scan(32'h4F_5B_06_3F, 6);
        scan(32'h07_7D_6D_66, 6);
        drive('0, 8'h00, 8);
        check("s4_valid", frame_valid_out, 1);
        check("s4_digits", digits_out, 16'h3210);
        check("s4_overrun", overrun_out, 1);
        check("s4_frames", presented - p0, 1);
        ready = 1'b1;
        @(posedge clk); #1;
        check("s4_valid_drop", frame_valid_out, 0);
        drive('0, 8'h00, 4);

        // random scanning against the model
        for (int k = 0; k < 300; k++) begin
            logic [N-1:0] s;
            logic [7:0] g;
            ready = $urandom_range(0, 3) != 0;
            s = ($urandom_range(0, 9) < 8) ? N'(1) << $urandom_range(0, N - 1) : N'($urandom_range(0, 15));
            g = ($urandom_range(0, 4) != 0) ? {1'($urandom_range(0, 1)), pat[$urandom_range(0, 11)]} : 8'($urandom);
            drive(s, g, $urandom_range(1, 7));
        end
        ready = 1'b1;
        drive('0, 8'h00, 12);
        check("rand_err", err_out, merr);
        check("rand_drained", expq.size(), 0);

        // reset mid-frame discards the partial frame
        do_reset();
        p0 = presented;
        drive(4'b0001, 8'h06, 6);
        drive(4'b0010, 8'h5B, 6);
        do_reset();
        scan(32'h00_40_6F_7F, 6);
        drive('0, 8'h00, 10);
        check("s5_frames", presented - p0, 1);
        check("s5_digits", digits_out, 16'hBA98);
        check("s5_err", err_out, 0);
        check("s5_overrun", overrun_out, 0);
        check("drained", expq.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
